// File: rtl/diff_amp_cmp_if.sv
// rtl/diff_amp_cmp_if.sv - sample/result bundle for the diff-amp comparator model
// Carries offset_trim only when DIFF_AMP_CMP_OFFSET_TRIM_EN is defined.
interface diff_amp_cmp_if #(
    parameter int WIDTH = 8
);
    logic        [WIDTH-1:0] vin_p;
    logic        [WIDTH-1:0] vin_n;
    logic                    tail_en;
    logic signed [WIDTH:0]   amp_out;
    logic                    cmp_out;
    logic                    valid;
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
    logic signed [3:0]       offset_trim;

    modport master (output vin_p, vin_n, tail_en, offset_trim, input amp_out, cmp_out, valid);
    modport slave  (input vin_p, vin_n, tail_en, offset_trim, output amp_out, cmp_out, valid);
`else
    modport master (output vin_p, vin_n, tail_en, input amp_out, cmp_out, valid);
    modport slave  (input vin_p, vin_n, tail_en, output amp_out, cmp_out, valid);
`endif
endinterface

// File: rtl/diff_amp_cmp.sv
// rtl/diff_amp_cmp.sv - 2-stage model of a 5T diff amp: saturated gain plus hysteretic comparator
// Optional input-pair offset trim enabled by DIFF_AMP_CMP_OFFSET_TRIM_EN.
module diff_amp_cmp #(
    parameter int WIDTH      = 8,
    parameter int GAIN_SHIFT = 3,
    parameter int HYST       = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    diff_amp_cmp_if.slave bus
);

`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
    localparam int DW = WIDTH + 2;
`else
    localparam int DW = WIDTH + 1;
`endif
    localparam int AW = DW + GAIN_SHIFT;

    localparam logic signed [AW-1:0] SAT_MAX = AW'((1 << WIDTH) - 1);
    localparam logic signed [AW-1:0] SAT_MIN = ~SAT_MAX;
    localparam logic signed [DW-1:0] HYST_P  = DW'(HYST);
    localparam logic signed [DW-1:0] HYST_N  = -HYST_P;

    logic        [WIDTH-1:0] vin_p_q;
    logic        [WIDTH-1:0] vin_n_q;
    logic                    tail_q;
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
    logic signed [3:0]       trim_q;
`endif

    logic signed [WIDTH:0]   amp_q, amp_d;
    logic                    cmp_q, cmp_d;
    logic                    valid_q, valid_d;

    logic signed [DW-1:0]    diff;
    logic signed [AW-1:0]    amp_full;

    always_comb begin
        diff = $signed({{(DW-WIDTH){1'b0}}, vin_p_q}) - $signed({{(DW-WIDTH){1'b0}}, vin_n_q});
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
        diff = diff + $signed({{(DW-4){trim_q[3]}}, trim_q});
`endif
        // Sign-extend before shifting so the full-scale product never wraps.
        amp_full = {{GAIN_SHIFT{diff[DW-1]}}, diff} << GAIN_SHIFT;

        amp_d   = '0;
        valid_d = 1'b0;
        cmp_d   = cmp_q;
        if (!tail_q) begin
            // Unbiased tail: the mirror load pulls the output node to the supply rail.
            cmp_d = 1'b1;
        end else begin
            valid_d = 1'b1;
            if (amp_full > SAT_MAX) begin
                amp_d = SAT_MAX[WIDTH:0];
            end else if (amp_full < SAT_MIN) begin
                amp_d = SAT_MIN[WIDTH:0];
            end else begin
                amp_d = amp_full[WIDTH:0];
            end
            if (!cmp_q && (diff > HYST_P)) begin
                cmp_d = 1'b1;
            end else if (cmp_q && (diff < HYST_N)) begin
                cmp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vin_p_q <= '0;
            vin_n_q <= '0;
            tail_q  <= 1'b0;
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
            trim_q  <= '0;
`endif
            amp_q   <= '0;
            cmp_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            vin_p_q <= bus.vin_p;
            vin_n_q <= bus.vin_n;
            tail_q  <= bus.tail_en;
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
            trim_q  <= bus.offset_trim;
`endif
            amp_q   <= amp_d;
            cmp_q   <= cmp_d;
            valid_q <= valid_d;
        end
    end

    assign bus.amp_out = amp_q;
    assign bus.cmp_out = cmp_q;
    assign bus.valid   = valid_q;

endmodule

// File: tb/tb_diff_amp_cmp.sv
// tb/tb_diff_amp_cmp.sv - scoreboard bench for diff_amp_cmp
// Exercises offset trim when DIFF_AMP_CMP_OFFSET_TRIM_EN is defined.
module tb_diff_amp_cmp;
    localparam int W    = 8;
    localparam int GS   = 3;
    localparam int HYST = 2;
    localparam int SMAX = (1 << W) - 1;
    localparam int SMIN = -(1 << W);

    typedef struct {
        logic signed [W:0] amp;
        logic              cmp;
        logic              valid;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    bit   m_cmp = 1'b0;
    exp_t sb [$];

    diff_amp_cmp_if #(.WIDTH(W)) bus ();

    diff_amp_cmp #(.WIDTH(W), .GAIN_SHIFT(GS), .HYST(HYST)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic exp_t model(int vp, int vn, bit te, int trim);
        exp_t e;
        int   d;
        int   a;
        d = vp - vn + trim;
        a = d * (1 << GS);
        if (!te) begin
            e.amp   = '0;
            e.valid = 1'b0;
            m_cmp   = 1'b1;
        end else begin
            if (a > SMAX) a = SMAX;
            if (a < SMIN) a = SMIN;
            e.amp   = (W+1)'(a);
            e.valid = 1'b1;
            if (!m_cmp && d > HYST) m_cmp = 1'b1;
            else if (m_cmp && d < -HYST) m_cmp = 1'b0;
        end
        e.cmp = m_cmp;
        return e;
    endfunction

    task automatic apply_now(int vp, int vn, bit te, int trim);
        bus.vin_p   = W'(vp);
        bus.vin_n   = W'(vn);
        bus.tail_en = te;
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
        bus.offset_trim = 4'(trim);
`endif
        sb.push_back(model(vp, vn, te, trim));
    endtask

    task automatic test_reset();
        exp_t e;
        apply_now(0, 0, 1'b0, 0);
        sb.delete();
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.amp_out, bus.cmp_out, bus.valid} !== 11'b0) begin
            errors++;
            $display("FAIL reset_hold: amp=%0d cmp=%b valid=%b, want 0/0/0", bus.amp_out, bus.cmp_out, bus.valid);
        end
        rst_n = 1'b1;
        m_cmp = 1'b1;
        apply_now(100, 96, 1'b1, 0);
        @(negedge clk);
        checks++;
        if ({bus.amp_out, bus.cmp_out, bus.valid} !== {9'sd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset_bubble: amp=%0d cmp=%b valid=%b, want 0/1/0", bus.amp_out, bus.cmp_out, bus.valid);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
            errors++;
            $display("FAIL reset_refill: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                     bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
        end
    endtask

    task automatic test_gain();
        int vp [5] = '{100, 10, 77, 96, 200};
        int vn [5] = '{96, 20, 77, 100, 190};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
                    errors++;
                    $display("FAIL gain[%0d]: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                             i-2, bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
                end
            end
            if (i < 5) apply_now(vp[i], vn[i], 1'b1, 0);
        end
    endtask

    task automatic test_saturation();
        int vp [5] = '{255, 0, 32, 0, 31};
        int vn [5] = '{0, 255, 0, 32, 0};
        exp_t e;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
                    errors++;
                    $display("FAIL sat[%0d]: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                             i-2, bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
                end
            end
            if (i < 5) apply_now(vp[i], vn[i], 1'b1, 0);
        end
    endtask

    task automatic test_hysteresis();
        int vp [6] = '{60, 50, 50, 50, 52, 53};
        int vn [6] = '{50, 51, 52, 53, 50, 50};
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
                    errors++;
                    $display("FAIL hyst[%0d]: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                             i-2, bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
                end
            end
            if (i < 6) apply_now(vp[i], vn[i], 1'b1, 0);
        end
    endtask

    task automatic test_tail_off();
        int vp [3] = '{0, 0, 0};
        int vn [3] = '{200, 10, 10};
        bit te [3] = '{1'b0, 1'b1, 1'b1};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
                    errors++;
                    $display("FAIL tail[%0d]: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                             i-2, bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
                end
            end
            if (i < 3) apply_now(vp[i], vn[i], te[i], 0);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   trim;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
                    errors++;
                    $display("FAIL b2b[%0d]: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                             i-2, bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
                end
            end
            if (i < 24) begin
                trim = 0;
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
                trim = int'($urandom_range(15)) - 8;
`endif
                if (i % 3 == 0) apply_now(128 + int'($urandom_range(6)) - 3, 128, ($urandom_range(4) != 0), trim);
                else apply_now(int'($urandom_range(255)), int'($urandom_range(255)), ($urandom_range(4) != 0), trim);
            end
        end
    endtask

`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
    task automatic test_offset_trim();
        int vp [3] = '{50, 50, 0};
        int vn [3] = '{50, 50, 255};
        int tr [3] = '{5, -8, -8};
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                e = sb.pop_front();
                checks++;
                if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
                    errors++;
                    $display("FAIL trim[%0d]: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                             i-2, bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
                end
            end
            if (i < 3) apply_now(vp[i], vn[i], 1'b1, tr[i]);
        end
        apply_now(50, 50, 1'b1, 0);
        sb.delete();
    endtask
`endif

    task automatic test_async_reset();
        exp_t e;
        @(negedge clk);
        apply_now(120, 100, 1'b1, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        checks++;
        if ({bus.amp_out, bus.valid} !== {9'sd160, 1'b1}) begin
            errors++;
            $display("FAIL pre_reset: amp=%0d valid=%b, want 160/1", bus.amp_out, bus.valid);
        end
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.amp_out, bus.cmp_out, bus.valid} !== 11'b0) begin
            errors++;
            $display("FAIL async_reset: amp=%0d cmp=%b valid=%b, want 0/0/0", bus.amp_out, bus.cmp_out, bus.valid);
        end
        @(negedge clk);
        rst_n = 1'b1;
        m_cmp = 1'b1;
        apply_now(0, 30, 1'b1, 0);
        @(negedge clk);
        checks++;
        if ({bus.amp_out, bus.cmp_out, bus.valid} !== {9'sd0, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL async_bubble: amp=%0d cmp=%b valid=%b, want 0/1/0", bus.amp_out, bus.cmp_out, bus.valid);
        end
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if ({bus.amp_out, bus.cmp_out, bus.valid} !== {e.amp, e.cmp, e.valid}) begin
            errors++;
            $display("FAIL async_refill: amp=%0d cmp=%b valid=%b, want %0d/%b/%b",
                     bus.amp_out, bus.cmp_out, bus.valid, e.amp, e.cmp, e.valid);
        end
    endtask

    initial begin
        test_reset();
        test_gain();
        test_saturation();
        test_hysteresis();
        test_tail_off();
        test_back_to_back();
`ifdef DIFF_AMP_CMP_OFFSET_TRIM_EN
        test_offset_trim();
`endif
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/diff_amp_cmp.md
Name: diff_amp_cmp

Overview:
- Cycle-based digital model of a 5-transistor differential amplifier: NMOS input pair, PMOS current-mirror load, NMOS tail source.
- Samples two unsigned input codes and produces a saturated amplified difference plus a 1-bit comparator decision with hysteresis.
- Serves as the behavioural stand-in for the analog diff-amp cell in mixed-signal digital regressions.

Parameters:
- WIDTH, 8, width of each unsigned input code.
- GAIN_SHIFT, 3, differential gain as a left shift (gain = 2^GAIN_SHIFT).
- HYST, 2, hysteresis threshold in LSBs; unsigned and less than 2^WIDTH.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- vin_p  input  WIDTH  non-inverting input code (gate of the mirror-diode-side NMOS).
- vin_n  input  WIDTH  inverting input code (gate of the output-side NMOS).
- tail_en  input  1  tail-source bias enable; 1 means biased.
- amp_out  output  WIDTH+1  signed, saturated amplified difference.
- cmp_out  output  1  comparator decision; 1 means vin_p is above vin_n.
- valid  output  1  high when amp_out and cmp_out reflect a biased sample.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n=0, asynchronous): all pipeline registers clear; amp_out=0, cmp_out=0, valid=0.
  - On the first edge after release, the pipeline refills normally.
- Stage 1 (edge k):
  - Register vin_p, vin_n and tail_en.
  - diff = vin_p - vin_n, computed signed in WIDTH+1 bits. Range is -(2^WIDTH-1) to +(2^WIDTH-1), with no overflow.
- Stage 2 (edge k+1), when the registered tail_en=1:
  - amp = diff * 2^GAIN_SHIFT, computed at full width.
  - Saturate amp to the signed WIDTH+1 range [-2^WIDTH, 2^WIDTH-1] and drive it on amp_out.
  - valid=1.
  - Comparator with hysteresis, relative to the current cmp_out:
    - If cmp_out=0 and diff > +HYST, cmp_out becomes 1.
    - If cmp_out=1 and diff < -HYST, cmp_out becomes 0.
    - Otherwise cmp_out holds.
    - With HYST=0, a diff of exactly 0 holds the state.
- Stage 2 (edge k+1), when the registered tail_en=0 (tail off, PMOS load pulls the output to the rail):
  - amp_out=0, valid=0, cmp_out forced to 1.
  - Hysteresis state is therefore 1 when bias returns.
- Latency: 2 cycles from input change to amp_out, cmp_out and valid.
- Throughput: one new sample per cycle; no handshake or backpressure.
- tail_en toggling: follows the same 2-cycle pipeline as the data; no glitching between edges.
- Equal inputs (vin_p == vin_n): amp_out=0 and cmp_out holds.
- Reset asserted mid-stream: all outputs go to 0 immediately (asynchronously), without waiting for a clock edge.

Optional Feature:
- Macro: DIFF_AMP_CMP_OFFSET_TRIM_EN.
- When defined:
  - Adds input port offset_trim (4 bits, signed, two's complement), registered in stage 1.
  - The registered value is added to diff before both gain and hysteresis comparison.
  - Arithmetic is widened to WIDTH+2 bits; saturation to the WIDTH+1 output range is unchanged.
  - Models input-pair mismatch correction.
- When undefined: no offset_trim port, and diff is used unmodified.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle while valid=1 -> amp_out=0, cmp_out=0, valid=0 before the next edge; after release with tail_en=1, valid=1 two edges later.
- Gain path: tail_en=1, vin_p=100, vin_n=96 -> two cycles later amp_out=+32, valid=1, cmp_out=1 (diff 4 > HYST 2).
- Saturation: vin_p=255, vin_n=0 -> amp_out=+255; vin_p=0, vin_n=255 -> amp_out=-256; cmp_out 1 then 0.
- Hysteresis:
  - From cmp_out=1, apply diffs -1, -2, -3 one per cycle -> cmp_out stays 1, 1, then becomes 0 on the -3 sample.
  - From cmp_out=0, diff +2 holds 0 and diff +3 sets 1.
- Tail off: tail_en=0 with vin_p=0, vin_n=200 -> two cycles later amp_out=0, valid=0, cmp_out=1; re-enable with diff -10 -> cmp_out=0 after 2 cycles.
- Offset trim (macro defined): vin_p=vin_n=50, offset_trim=+5 -> amp_out=+40, cmp_out=1; offset_trim=-8 -> amp_out=-64, cmp_out=0.
